gpio_output_ip: RTL



---
 rtl/gpio_output_ip_if.sv | 27 ++
 rtl/gpio_output_ip.sv | 127 ++++++++++++
 2 files changed

// File: rtl/gpio_output_ip_if.sv
// Local-bus write/read channel of the GPIO output peripheral.
// The master drives address/data/enables; the slave returns wready, rdata and rvalid.
interface gpio_output_ip_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic [STRB_W-1:0] wstrb;
    logic              wready;
    logic [ADDR_W-1:0] raddr;
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output waddr, wdata, wen, wstrb, raddr, ren,
        input  wready, rdata, rvalid
    );

    modport slave (
        input  waddr, wdata, wen, wstrb, raddr, ren,
        output wready, rdata, rvalid
    );
endinterface

// File: rtl/gpio_output_ip.sv
// 16-bit GPIO output register with DATA/SET/CLR/TOG write aliases and registered reads.
// Define GPIO_OUT_BLINK_EN to add the blink engine (BLINK_MASK at 0x10, BLINK_PERIOD at 0x14).
module gpio_output_ip #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          STRB_W    = DATA_W / 8,
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    gpio_output_ip_if.slave     bus,
    output logic [15:0]         csr_gpio_out_data_out
);

    localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_SET    = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_CLR    = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_TOG    = ADDR_W'(32'h0C);
`ifdef GPIO_OUT_BLINK_EN
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(32'h14);
`endif

    logic [15:0]       out_q;
    logic [15:0]       out_nxt;
    logic [15:0]       bytemask;
    logic [15:0]       wd;
    logic [DATA_W-1:0] rd_nxt;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic              unused_bits;

    // Only the low two strobes and low half-word take part in any register.
    assign unused_bits = ^{bus.wdata[DATA_W-1:16], bus.wstrb[STRB_W-1:2]};

    assign bytemask = {{8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
    assign wd       = bus.wdata[15:0] & bytemask;

    function automatic logic [15:0] merge_bytes(input logic [15:0] old_val,
                                                input logic [15:0] new_val,
                                                input logic [15:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

`ifdef GPIO_OUT_BLINK_EN
    logic [15:0] mask_q;
    logic [15:0] period_q;
    logic [15:0] cnt_q;
    logic        tick;
    logic        period_wr;

    assign tick      = (period_q != 16'd0) && (cnt_q == period_q);
    assign period_wr = bus.wen && (bus.waddr == A_PERIOD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 16'd0;
            mask_q   <= 16'd0;
            period_q <= 16'd0;
        end else begin
            // A PERIOD write restarts the count from zero on the same edge.
            if (period_wr || tick || (period_q == 16'd0))
                cnt_q <= 16'd0;
            else
                cnt_q <= cnt_q + 16'd1;
            if (bus.wen && (bus.waddr == A_MASK))
                mask_q <= merge_bytes(mask_q, bus.wdata[15:0], bytemask);
            if (period_wr)
                period_q <= merge_bytes(period_q, bus.wdata[15:0], bytemask);
        end
    end
`endif

    always_comb begin
        out_nxt = out_q;
        if (bus.wen) begin
            case (bus.waddr)
                A_DATA:  out_nxt = merge_bytes(out_q, bus.wdata[15:0], bytemask);
                A_SET:   out_nxt = out_q | wd;
                A_CLR:   out_nxt = out_q & ~wd;
                A_TOG:   out_nxt = out_q ^ wd;
                default: out_nxt = out_q;
            endcase
        end
`ifdef GPIO_OUT_BLINK_EN
        // The blink toggle lands on top of whatever the bus wrote this edge.
        if (tick)
            out_nxt = out_nxt ^ mask_q;
`endif
    end

    always_comb begin
        rd_nxt = '0;
        case (bus.raddr)
            A_DATA:   rd_nxt[15:0] = out_q;
`ifdef GPIO_OUT_BLINK_EN
            A_MASK:   rd_nxt[15:0] = mask_q;
            A_PERIOD: rd_nxt[15:0] = period_q;
`endif
            default:  rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_q <= RESET_VAL;
        else
            out_q <= out_nxt;
    end

    // Read stage: decode registered one cycle after ren.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            rdata_p1 <= bus.ren ? rd_nxt : '0;
            vld_p1   <= bus.ren;
        end
    end

    assign bus.rdata             = rdata_p1;
    assign bus.rvalid            = vld_p1;
    assign bus.wready            = 1'b1;
    assign csr_gpio_out_data_out = out_q;

endmodule
